// File: rtl/hack_io_hub_if.sv
// rtl/hack_io_hub_if.sv - CPU-side register bus for the Hack I/O hub
interface hack_io_hub_if;
  logic [2:0]  addr;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/hack_io_hub.sv
// rtl/hack_io_hub.sv - memory-mapped switches, buttons, LEDs, 7-seg scanner and tick timer
module hack_io_hub #(
  parameter int NUM_BTN            = 5,
  parameter int NUM_SW             = 16,
  parameter int NUM_LED            = 16,
  parameter int SEG_DIGITS         = 4,
  parameter int DEBOUNCE_CYCLES    = 1_000_000,
  parameter int SEG_REFRESH_CYCLES = 100_000,
  parameter int TICK_CYCLES        = 100_000
) (
  input  logic               clk,
  input  logic               reset_n,
  hack_io_hub_if.slave       bus,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_SW-1:0]  sw_raw,
  output logic [NUM_LED-1:0] led,
  output logic [6:0]         seg,
  output logic [3:0]         an,
  output logic               dp
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int REF_W = (SEG_REFRESH_CYCLES > 1) ? $clog2(SEG_REFRESH_CYCLES) : 1;
  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(SEG_REFRESH_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
  localparam logic [1:0]       IDX_LAST = 2'(SEG_DIGITS - 1);

  // Register-bus write decode; offsets 0, 1 and 7 are not writable.
  logic wr_seg, wr_led, wr_evt, wr_timer, wr_ctrl;
  assign wr_seg   = bus.we && (bus.addr == 3'd2);
  assign wr_led   = bus.we && (bus.addr == 3'd3);
  assign wr_evt   = bus.we && (bus.addr == 3'd4);
  assign wr_timer = bus.we && (bus.addr == 3'd5);
  assign wr_ctrl  = bus.we && (bus.addr == 3'd6);

  // Storage
  logic [NUM_SW-1:0]  sw_s1, sw_s2;
  logic [NUM_BTN-1:0] btn_s1, btn_s2;
  logic [NUM_BTN-1:0] btn_lvl;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_evt;
  logic [NUM_BTN-1:0] evt_clr;
  logic [15:0]        seg_reg;
  logic [15:0]        led_reg;
  logic [7:0]         seg_ctrl;
  logic [15:0]        timer;
  logic [PRE_W-1:0]   presc;
  logic [REF_W-1:0]   ref_cnt;
  logic [1:0]         scan_idx;
  logic [3:0]         an_q;
  logic [6:0]         seg_q;
  logic               dp_q;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] on;
    on = 7'h00;
    case (v)
      4'h0: on = 7'h3F;
      4'h1: on = 7'h06;
      4'h2: on = 7'h5B;
      4'h3: on = 7'h4F;
      4'h4: on = 7'h66;
      4'h5: on = 7'h6D;
      4'h6: on = 7'h7D;
      4'h7: on = 7'h07;
      4'h8: on = 7'h7F;
      4'h9: on = 7'h6F;
      4'hA: on = 7'h77;
      4'hB: on = 7'h7C;
      4'hC: on = 7'h39;
      4'hD: on = 7'h5E;
      4'hE: on = 7'h79;
      4'hF: on = 7'h71;
    endcase
    return ~on;
  endfunction

  // Two-flop synchronisers for the asynchronous switch and button pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= sw_raw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  // A rising debounced level is the cycle the counter expires with the synced input high.
  always_comb begin
    btn_rise = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      btn_rise[i] = ~btn_lvl[i] & btn_s2[i] & (db_cnt[i] == DB_LAST);
    end
  end

  // Per-channel debounce: level follows the synced input only after a full run of disagreement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_lvl <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_s2[i] == btn_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_lvl[i] <= btn_s2[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign evt_clr = wr_evt ? bus.wdata[NUM_BTN-1:0] : '0;

  // Sticky press events: a new edge is OR-ed in after the clear so it is never dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_evt <= '0;
    end else begin
      btn_evt <= (btn_evt & ~evt_clr) | btn_rise;
    end
  end

  // Plain read/write registers: digits, LEDs and display control.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_reg  <= 16'h0000;
      led_reg  <= 16'h0000;
      seg_ctrl <= 8'h0F;
    end else begin
      if (wr_seg) seg_reg <= bus.wdata;
      if (wr_led) led_reg <= bus.wdata;
      if (wr_ctrl) seg_ctrl <= bus.wdata[7:0];
    end
  end

  // Tick timer: prescaler divides clk, a CPU load overrides a coincident tick and restarts the prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      timer <= 16'h0000;
    end else if (wr_timer) begin
      presc <= '0;
      timer <= bus.wdata;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
      timer <= timer + 16'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Digit scan index: holds each digit for one refresh period, wraps after the last fitted digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt  <= '0;
      scan_idx <= 2'd0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt  <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? 2'd0 : scan_idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  logic       digit_on;
  logic [3:0] nibble;
  assign digit_on = seg_ctrl[scan_idx];
  assign nibble   = seg_reg[{scan_idx, 2'b00} +: 4];

  // Display drive registered so anode, segments and DP switch on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= digit_on ? ~(4'b0001 << scan_idx) : 4'hF;
      seg_q <= digit_on ? hex7(nibble) : 7'h7F;
      dp_q  <= ~seg_ctrl[{1'b1, scan_idx}];
    end
  end

  // Combinational read mux; the CPU samples this directly as inM.
  always_comb begin
    bus.rdata = 16'h0000;
    case (bus.addr)
      3'd0: bus.rdata = 16'(sw_s2);
      3'd1: bus.rdata = 16'(btn_lvl);
      3'd2: bus.rdata = seg_reg;
      3'd3: bus.rdata = led_reg;
      3'd4: bus.rdata = 16'(btn_evt);
      3'd5: bus.rdata = timer;
      3'd6: bus.rdata = {8'h00, seg_ctrl};
      default: bus.rdata = 16'h0000;
    endcase
  end

  assign led = led_reg[NUM_LED-1:0];
  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_hack_io_hub.sv
// tb/tb_hack_io_hub.sv - scoreboard bench for hack_io_hub
module tb_hack_io_hub;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  btn_raw = '0;
  logic [15:0] sw_raw = '0;
  logic [15:0] led;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  hack_io_hub_if bus();

  hack_io_hub #(
    .NUM_BTN(5), .NUM_SW(16), .NUM_LED(16), .SEG_DIGITS(4),
    .DEBOUNCE_CYCLES(4), .SEG_REFRESH_CYCLES(2), .TICK_CYCLES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .btn_raw(btn_raw), .sw_raw(sw_raw),
    .led(led), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q [$];
  logic [11:0] scan_q [$];

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] got, exp;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({led, an, seg, dp} !== {16'h0000, 4'hF, 7'h7F, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_pins: got led=%h an=%b seg=%h dp=%b expected 0000/1111/7f/1", led, an, seg, dp);
    end
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h000F);
    for (int a = 2; a <= 6; a++) begin
      rd(3'(a), got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL reset_reg%0d: got %h expected %h", a, got, exp);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_timer();
    logic [15:0] got, exp;
    apply_reset();
    exp_q.push_back(16'h0000);
    repeat (2) @(negedge clk);
    rd(3'd5, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL timer_pre_tick: got %h expected %h", got, exp); end
    exp_q.push_back(16'h0001);
    @(negedge clk);
    rd(3'd5, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL timer_first_tick: got %h expected %h", got, exp); end
    wr(3'd5, 16'hFFFF);
    exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000);
    repeat (2) @(negedge clk);
    rd(3'd5, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL timer_load_hold: got %h expected %h", got, exp); end
    @(negedge clk);
    rd(3'd5, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL timer_wrap: got %h expected %h", got, exp); end
    @(negedge clk);
    wr(3'd5, 16'h1234);
    exp_q.push_back(16'h1234); exp_q.push_back(16'h1235);
    rd(3'd5, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL timer_write_at_tick: got %h expected %h", got, exp); end
    repeat (3) @(negedge clk);
    rd(3'd5, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL timer_after_load: got %h expected %h", got, exp); end
  endtask

  task automatic test_debounce();
    logic [15:0] got, exp;
    apply_reset();
    btn_raw[0] = 1'b1;
    repeat (3) @(negedge clk);
    btn_raw[0] = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    rd(3'd1, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL glitch_btn: got %h expected %h", got, exp); end
    rd(3'd4, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL glitch_evt: got %h expected %h", got, exp); end
    btn_raw[0] = 1'b1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001); exp_q.push_back(16'h0001);
    repeat (5) @(negedge clk);
    rd(3'd1, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL btn_too_early: got %h expected %h", got, exp); end
    repeat (3) @(negedge clk);
    rd(3'd1, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL btn_held: got %h expected %h", got, exp); end
    rd(3'd4, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL evt_held: got %h expected %h", got, exp); end
    btn_raw[0] = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    rd(3'd1, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL btn_release: got %h expected %h", got, exp); end
    rd(3'd4, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL evt_sticky: got %h expected %h", got, exp); end
  endtask

  task automatic test_w1c();
    logic [15:0] got, exp;
    btn_raw[1] = 1'b1;
    repeat (8) @(negedge clk);
    btn_raw[1] = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.push_back(16'h0003);
    rd(3'd4, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL evt_two: got %h expected %h", got, exp); end
    btn_raw[1] = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(16'h0000);
    rd(3'd1, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL btn1_not_yet: got %h expected %h", got, exp); end
    wr(3'd4, 16'h0003);
    exp_q.push_back(16'h0002);
    rd(3'd4, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL evt_set_wins: got %h expected %h", got, exp); end
    wr(3'd4, 16'h0000);
    exp_q.push_back(16'h0002);
    rd(3'd4, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL evt_w0_keeps: got %h expected %h", got, exp); end
    wr(3'd4, 16'h0002);
    exp_q.push_back(16'h0000);
    rd(3'd4, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL evt_w1c: got %h expected %h", got, exp); end
    btn_raw[1] = 1'b0;
  endtask

  task automatic test_scan();
    logic [15:0] got, exp;
    logic [11:0] sexp;
    logic [3:0]  prev;
    bit          found;
    apply_reset();
    wr(3'd2, 16'h1234);
    wr(3'd6, 16'hFF15);
    exp_q.push_back(16'h1234); exp_q.push_back(16'h0015);
    rd(3'd2, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL seg_readback: got %h expected %h", got, exp); end
    rd(3'd6, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL ctrl_readback: got %h expected %h", got, exp); end
    repeat (2) @(negedge clk);
    found = 1'b0;
    prev = an;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an === 4'b1110 && prev !== 4'b1110) found = 1'b1;
      else prev = an;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL scan_align: got an=%b expected a 1111->1110 transition within 40 cycles", an);
    end
    for (int p = 0; p < 2; p++) begin
      repeat (2) scan_q.push_back({4'b1110, 7'h19, 1'b0});
      repeat (2) scan_q.push_back({4'b1111, 7'h7F, 1'b1});
      repeat (2) scan_q.push_back({4'b1011, 7'h24, 1'b1});
      repeat (2) scan_q.push_back({4'b1111, 7'h7F, 1'b1});
    end
    for (int k = 0; k < 16; k++) begin
      sexp = scan_q.pop_front();
      n_cmp++;
      if ({an, seg, dp} !== sexp) begin
        n_bad++;
        $display("FAIL scan_cycle%0d: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                 k, an, seg, dp, sexp[11:8], sexp[7:1], sexp[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_led();
    logic [15:0] got, exp;
    sw_raw = 16'hA5A5;
    exp_q.push_back(16'h0000); exp_q.push_back(16'hA5A5);
    @(negedge clk);
    rd(3'd0, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL sw_one_cycle: got %h expected %h", got, exp); end
    @(negedge clk);
    rd(3'd0, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL sw_two_cycles: got %h expected %h", got, exp); end
    wr(3'd3, 16'hBEEF);
    exp_q.push_back(16'hBEEF); exp_q.push_back(16'hBEEF);
    exp = exp_q.pop_front(); n_cmp++;
    if (led !== exp) begin n_bad++; $display("FAIL led_pins: got %h expected %h", led, exp); end
    rd(3'd3, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL led_readback: got %h expected %h", got, exp); end
    wr(3'd0, 16'h1234);
    wr(3'd7, 16'hFFFF);
    exp_q.push_back(16'hA5A5); exp_q.push_back(16'h0000);
    rd(3'd0, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL sw_ro_write: got %h expected %h", got, exp); end
    rd(3'd7, got); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL unmapped_read: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    wr(3'd3, 16'hFFFF);
    n_cmp++;
    if (led !== 16'hFFFF) begin n_bad++; $display("FAIL led_all_on: got %h expected ffff", led); end
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({led, an, seg, dp} !== {16'h0000, 4'hF, 7'h7F, 1'b1}) begin
      n_bad++;
      $display("FAIL async_reset: got led=%h an=%b seg=%h dp=%b expected 0000/1111/7f/1", led, an, seg, dp);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.addr  = 3'd0;
    bus.we    = 1'b0;
    bus.wdata = 16'h0000;
    test_reset();
    test_timer();
    test_debounce();
    test_w1c();
    test_scan();
    test_sw_led();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
